dsram_access_ctrl: RTL and testbench
====================================

// Module: dsram_access_ctrl
// PURPOSE
//  MEM-stage data-memory access controller for the MIPS core. Accepts one load/store per
//  mem_valid, checks alignment, then drives the SRAM-like data bus (req/addr_ok/data_ok).
//  Stalls the pipeline until the transaction completes and returns the extended load data.
//  Flags ADEL/ADES to CP0 and drains in-flight transactions on flush.
// PARAMETERS
//  TIMEOUT   255  data_ok watchdog limit in cycles (used only with DSRAM_TIMEOUT_EN)
// PORTS
//  clk           in   1   single clock, rising edge
//  rst           in   1   synchronous, active-high reset
//  mem_valid     in   1   MEM stage holds a memory op
//  mem_op        in   8   EXE_{LB,LBU,LH,LHU,LW,SB,SH,SW}_OP code
//  mem_addr      in   32  byte address
//  mem_wdata     in   32  store data (right-justified)
//  flush         in   1   exception/eret flush from CP0
//  mem_rdata     out  32  load result, sign/zero-extended
//  mem_done      out  1   1-cycle completion pulse
//  stall         out  1   hold IF..MEM
//  adel, ades    out  1   load/store address error (combinational)
//  badvaddr      out  32  faulting address (= mem_addr)
//  data_req      out  1   bus request
//  data_wr       out  1   1 = store
//  data_size     out  2   0 byte, 1 half, 2 word
//  data_addr     out  32  bus address
//  data_wdata    out  32  lane-aligned store data
//  data_wstrb    out  4   byte enables (0000 on loads)
//  data_addr_ok  in   1   request accepted
//  data_data_ok  in   1   response valid / write done
//  data_rdata    in   32  read data
//  bus_err       out  1   watchdog expiry pulse (DSRAM_TIMEOUT_EN only)
// BEHAVIOUR
//  Reset: state IDLE; every output 0, mem_rdata 0.
//  Alignment: LH/LHU/SH need addr[0]=0; LW/SW need addr[1:0]=0. On a violation while
//   mem_valid & IDLE: adel/ades=1 the same cycle; no request; stall=0; mem_done=0.
//  Non-memory op codes with mem_valid: ignored (no request, no pulse).
//  FSM IDLE,REQ,WAIT,DONE,DRAIN:
//   IDLE : legal aligned op & !flush -> register addr/wdata/strb/size/op; stall=1
//          combinationally; -> REQ.
//   REQ  : data_req=1; address/data held stable until addr_ok.
//          addr_ok&data_ok -> DONE; addr_ok -> WAIT.
//          flush&!addr_ok -> IDLE (request withdrawn); flush&addr_ok -> DRAIN.
//   WAIT : data_ok -> DONE and latch extended rdata; flush -> DRAIN
//          (flush&data_ok -> IDLE, data discarded).
//   DONE : mem_done=1, stall=0, mem_rdata valid; -> IDLE. No new accept this cycle.
//   DRAIN: data_req=0; await data_ok, discard; no mem_done; stall=mem_valid; -> IDLE.
//  Latency with zero-wait bus: accept cycle 0, REQ cycle 1, DONE pulse cycle 2.
//  Store lanes: SB strb=0001<<a[1:0], wdata=wdata<<8*a[1:0]; SH strb 0011/1100 by a[1],
//   wdata<<16*a[1]; SW 1111.
//  Load extract: LB/LBU byte a[1:0], LH/LHU half a[1]; sign- or zero-extend; LW as is.
//  data_addr = mem_addr; no address translation.
//  Reset mid-transaction returns to IDLE at once; a late data_ok is ignored in IDLE.
// CONFIGURATION
//  DSRAM_TIMEOUT_EN defined: 8-bit counter clears on entry to REQ, counts in
//   REQ/WAIT/DRAIN. At TIMEOUT: bus_err=1 for 1 cycle, data_req dropped, -> IDLE,
//   no mem_done.
//  Undefined: controller waits indefinitely; bus_err port and counter are absent.
// STRUCTURE
//  defines.vh: EXE_*_OP codes (existing); add DSRAM_S_* state encodings and SIZE_* codes.
//  Sub-module dsram_align (combinational) provides strb/wdata lane shift, load
//   extraction and the adel/ades checks. The FSM stays in dsram_access_ctrl.
// TESTING
//  SW addr 0x100, wdata 0xDEADBEEF, zero-wait bus -> strb 1111, size 2, mem_done cycle 2.
//  LB addr 0x103, rdata 0x80xxxxxx, data_ok 3 cycles after addr_ok
//   -> mem_rdata 0xFFFFFF80; stall held the whole time.
//  LH addr 0x101 -> adel=1, badvaddr 0x101, data_req never asserted.
//  SH addr 0x202 -> ades=0, strb 1100, data_wdata = wdata<<16.
//  LW accepted, flush in WAIT -> DRAIN; data_ok discarded, no mem_done, then IDLE.
//  DSRAM_TIMEOUT_EN, TIMEOUT=4, addr_ok never -> bus_err pulse 4 cycles after REQ, then IDLE.

Source files
------------

// File: rtl/dsram_access_ctrl_pkg.sv
// Opcodes, bus size codes, FSM state encodings and the request payload
// shared by the MEM-stage data-SRAM access controller.
package dsram_access_ctrl_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned OP_W   = 8;
  localparam int unsigned STRB_W = XLEN / 8;

  localparam logic [OP_W-1:0] EXE_LB_OP  = 8'b1110_0000;
  localparam logic [OP_W-1:0] EXE_LH_OP  = 8'b1110_0001;
  localparam logic [OP_W-1:0] EXE_LW_OP  = 8'b1110_0011;
  localparam logic [OP_W-1:0] EXE_LBU_OP = 8'b1110_0100;
  localparam logic [OP_W-1:0] EXE_LHU_OP = 8'b1110_0101;
  localparam logic [OP_W-1:0] EXE_SB_OP  = 8'b1110_1000;
  localparam logic [OP_W-1:0] EXE_SH_OP  = 8'b1110_1001;
  localparam logic [OP_W-1:0] EXE_SW_OP  = 8'b1110_1011;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  typedef enum logic [2:0] {
    DSRAM_S_IDLE  = 3'd0,
    DSRAM_S_REQ   = 3'd1,
    DSRAM_S_WAIT  = 3'd2,
    DSRAM_S_DONE  = 3'd3,
    DSRAM_S_DRAIN = 3'd4
  } dsram_state_e;

  typedef struct packed {
    logic              wr;
    logic [1:0]        size;
    logic [XLEN-1:0]   addr;
    logic [XLEN-1:0]   wdata;
    logic [STRB_W-1:0] strb;
  } dsram_req_t;

endpackage

// File: rtl/dsram_access_ctrl_align.sv
// Combinational lane logic: alignment checks, store byte-enables/data shift,
// and load byte/half extraction with sign or zero extension.
module dsram_access_ctrl_align
  import dsram_access_ctrl_pkg::*;
(
  input  logic [OP_W-1:0]   req_op_i,
  input  logic [1:0]        req_addr_lo_i,
  input  logic [XLEN-1:0]   req_wdata_i,
  input  logic [OP_W-1:0]   rsp_op_i,
  input  logic [1:0]        rsp_addr_lo_i,
  input  logic [XLEN-1:0]   rsp_rdata_i,
  output logic              req_is_mem_o,
  output logic              req_is_store_o,
  output logic              adel_o,
  output logic              ades_o,
  output logic [1:0]        req_size_o,
  output logic [STRB_W-1:0] req_strb_o,
  output logic [XLEN-1:0]   req_wdata_o,
  output logic [XLEN-1:0]   rsp_data_o
);

  logic [7:0]  rsp_byte;
  logic [15:0] rsp_half;

  always_comb begin
    req_is_mem_o   = 1'b0;
    req_is_store_o = 1'b0;
    adel_o         = 1'b0;
    ades_o         = 1'b0;
    req_size_o     = SIZE_WORD;
    req_strb_o     = '0;
    req_wdata_o    = '0;
    case (req_op_i)
      EXE_LB_OP, EXE_LBU_OP: begin
        req_is_mem_o = 1'b1;
        req_size_o   = SIZE_BYTE;
      end
      EXE_LH_OP, EXE_LHU_OP: begin
        req_is_mem_o = 1'b1;
        req_size_o   = SIZE_HALF;
        adel_o       = req_addr_lo_i[0];
      end
      EXE_LW_OP: begin
        req_is_mem_o = 1'b1;
        adel_o       = |req_addr_lo_i;
      end
      EXE_SB_OP: begin
        req_is_mem_o   = 1'b1;
        req_is_store_o = 1'b1;
        req_size_o     = SIZE_BYTE;
        req_strb_o     = STRB_W'(4'b0001 << req_addr_lo_i);
        req_wdata_o    = req_wdata_i << {req_addr_lo_i, 3'b000};
      end
      EXE_SH_OP: begin
        req_is_mem_o   = 1'b1;
        req_is_store_o = 1'b1;
        req_size_o     = SIZE_HALF;
        ades_o         = req_addr_lo_i[0];
        req_strb_o     = req_addr_lo_i[1] ? 4'b1100 : 4'b0011;
        req_wdata_o    = req_addr_lo_i[1] ? {req_wdata_i[15:0], 16'h0000} : req_wdata_i;
      end
      EXE_SW_OP: begin
        req_is_mem_o   = 1'b1;
        req_is_store_o = 1'b1;
        ades_o         = |req_addr_lo_i;
        req_strb_o     = 4'b1111;
        req_wdata_o    = req_wdata_i;
      end
      default: ;
    endcase
  end

  // Load side uses the latched op/address, not the live MEM-stage inputs.
  always_comb begin
    case (rsp_addr_lo_i)
      2'd0:    rsp_byte = rsp_rdata_i[7:0];
      2'd1:    rsp_byte = rsp_rdata_i[15:8];
      2'd2:    rsp_byte = rsp_rdata_i[23:16];
      default: rsp_byte = rsp_rdata_i[31:24];
    endcase
    rsp_half = rsp_addr_lo_i[1] ? rsp_rdata_i[31:16] : rsp_rdata_i[15:0];
    case (rsp_op_i)
      EXE_LB_OP:  rsp_data_o = {{24{rsp_byte[7]}}, rsp_byte};
      EXE_LBU_OP: rsp_data_o = {24'h000000, rsp_byte};
      EXE_LH_OP:  rsp_data_o = {{16{rsp_half[15]}}, rsp_half};
      EXE_LHU_OP: rsp_data_o = {16'h0000, rsp_half};
      default:    rsp_data_o = rsp_rdata_i;
    endcase
  end

endmodule

// File: rtl/dsram_access_ctrl.sv
// MEM-stage data-SRAM access controller: one load/store per op, stalls until done.
// Optional data_ok watchdog with bus_err_o when DSRAM_TIMEOUT_EN is defined.
module dsram_access_ctrl
  import dsram_access_ctrl_pkg::*;
`ifdef DSRAM_TIMEOUT_EN
#(
  parameter int unsigned TIMEOUT = 255
)
`endif
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              mem_valid_i,
  input  logic [OP_W-1:0]   mem_op_i,
  input  logic [XLEN-1:0]   mem_addr_i,
  input  logic [XLEN-1:0]   mem_wdata_i,
  input  logic              flush_i,
  output logic [XLEN-1:0]   mem_rdata_o,
  output logic              mem_done_o,
  output logic              stall_o,
  output logic              adel_o,
  output logic              ades_o,
  output logic [XLEN-1:0]   badvaddr_o,
  output logic              data_req_o,
  output logic              data_wr_o,
  output logic [1:0]        data_size_o,
  output logic [XLEN-1:0]   data_addr_o,
  output logic [XLEN-1:0]   data_wdata_o,
  output logic [STRB_W-1:0] data_wstrb_o,
  input  logic              data_addr_ok_i,
  input  logic              data_data_ok_i,
  input  logic [XLEN-1:0]   data_rdata_i
`ifdef DSRAM_TIMEOUT_EN
  ,
  output logic              bus_err_o
`endif
);

  dsram_state_e      state_q;
  dsram_req_t        req_q, req_d;
  logic [OP_W-1:0]   op_q;
  logic              data_req_q, mem_done_q;
  logic [XLEN-1:0]   rdata_q;

  logic              is_mem, is_store, adel_a, ades_a, accept_c, expire_c;
  logic [1:0]        size_a;
  logic [STRB_W-1:0] strb_a;
  logic [XLEN-1:0]   wdata_a, load_data;

  dsram_access_ctrl_align u_align (
    .req_op_i       (mem_op_i),
    .req_addr_lo_i  (mem_addr_i[1:0]),
    .req_wdata_i    (mem_wdata_i),
    .rsp_op_i       (op_q),
    .rsp_addr_lo_i  (req_q.addr[1:0]),
    .rsp_rdata_i    (data_rdata_i),
    .req_is_mem_o   (is_mem),
    .req_is_store_o (is_store),
    .adel_o         (adel_a),
    .ades_o         (ades_a),
    .req_size_o     (size_a),
    .req_strb_o     (strb_a),
    .req_wdata_o    (wdata_a),
    .rsp_data_o     (load_data)
  );

  assign accept_c = (state_q == DSRAM_S_IDLE) && mem_valid_i && is_mem &&
                    !adel_a && !ades_a && !flush_i;
  assign adel_o     = (state_q == DSRAM_S_IDLE) && mem_valid_i && adel_a;
  assign ades_o     = (state_q == DSRAM_S_IDLE) && mem_valid_i && ades_a;
  assign badvaddr_o = mem_addr_i;

  always_comb begin
    req_d.wr    = is_store;
    req_d.size  = size_a;
    req_d.addr  = mem_addr_i;
    req_d.wdata = wdata_a;
    req_d.strb  = strb_a;
  end

  // Stall rises in the accept cycle itself and drops in the DONE cycle.
  always_comb begin
    stall_o = 1'b0;
    case (state_q)
      DSRAM_S_IDLE:              stall_o = accept_c;
      DSRAM_S_REQ, DSRAM_S_WAIT: stall_o = 1'b1;
      DSRAM_S_DRAIN:             stall_o = mem_valid_i;
      default:                   stall_o = 1'b0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= DSRAM_S_IDLE;
      req_q      <= '0;
      op_q       <= '0;
      data_req_q <= 1'b0;
      mem_done_q <= 1'b0;
      rdata_q    <= '0;
    end else begin
      mem_done_q <= 1'b0;
      case (state_q)
        DSRAM_S_IDLE: begin
          if (accept_c) begin
            state_q    <= DSRAM_S_REQ;
            req_q      <= req_d;
            op_q       <= mem_op_i;
            data_req_q <= 1'b1;
          end
        end
        DSRAM_S_REQ: begin
          if ((flush_i && !data_addr_ok_i) || expire_c) begin
            state_q    <= DSRAM_S_IDLE;
            data_req_q <= 1'b0;
          end else if (data_addr_ok_i) begin
            data_req_q <= 1'b0;
            if (data_data_ok_i && flush_i) begin
              state_q <= DSRAM_S_IDLE;
            end else if (data_data_ok_i) begin
              state_q    <= DSRAM_S_DONE;
              mem_done_q <= 1'b1;
              rdata_q    <= load_data;
            end else begin
              state_q <= flush_i ? DSRAM_S_DRAIN : DSRAM_S_WAIT;
            end
          end
        end
        DSRAM_S_WAIT: begin
          if (expire_c || (data_data_ok_i && flush_i)) begin
            state_q <= DSRAM_S_IDLE;
          end else if (data_data_ok_i) begin
            state_q    <= DSRAM_S_DONE;
            mem_done_q <= 1'b1;
            rdata_q    <= load_data;
          end else if (flush_i) begin
            state_q <= DSRAM_S_DRAIN;
          end
        end
        DSRAM_S_DRAIN: begin
          if (expire_c || data_data_ok_i) state_q <= DSRAM_S_IDLE;
        end
        default: state_q <= DSRAM_S_IDLE;
      endcase
    end
  end

`ifdef DSRAM_TIMEOUT_EN
  localparam int unsigned CNT_W = 8;
  logic [CNT_W-1:0] cnt_q;
  logic             bus_err_q, busy_c, resp_c;

  // A response landing on the expiry cycle still completes normally.
  always_comb begin
    busy_c   = (state_q == DSRAM_S_REQ) || (state_q == DSRAM_S_WAIT) ||
               (state_q == DSRAM_S_DRAIN);
    resp_c   = (state_q == DSRAM_S_REQ) ? (data_addr_ok_i && data_data_ok_i)
                                        : data_data_ok_i;
    expire_c = busy_c && (cnt_q == CNT_W'(TIMEOUT - 1)) && !resp_c;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q     <= '0;
      bus_err_q <= 1'b0;
    end else begin
      bus_err_q <= expire_c;
      if (accept_c)    cnt_q <= '0;
      else if (busy_c) cnt_q <= cnt_q + 1'b1;
    end
  end

  assign bus_err_o = bus_err_q;
`else
  assign expire_c = 1'b0;
`endif

  assign mem_rdata_o  = rdata_q;
  assign mem_done_o   = mem_done_q;
  assign data_req_o   = data_req_q;
  assign data_wr_o    = req_q.wr;
  assign data_size_o  = req_q.size;
  assign data_addr_o  = req_q.addr;
  assign data_wdata_o = req_q.wdata;
  assign data_wstrb_o = req_q.strb;

endmodule

// File: tb/tb_dsram_access_ctrl.sv
// Directed bench for dsram_access_ctrl; the watchdog test runs only with DSRAM_TIMEOUT_EN.
module tb_dsram_access_ctrl;
  import dsram_access_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_valid, flush, addr_ok, data_ok;
  logic [7:0]  mem_op;
  logic [31:0] mem_addr, mem_wdata, rdata_in;
  logic [31:0] mem_rdata, badvaddr, data_addr, data_wdata;
  logic        mem_done, stall, adel, ades, data_req, data_wr;
  logic [1:0]  data_size;
  logic [3:0]  data_wstrb;
`ifdef DSRAM_TIMEOUT_EN
  logic        bus_err;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

`ifdef DSRAM_TIMEOUT_EN
  dsram_access_ctrl #(.TIMEOUT(4)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .mem_valid_i    (mem_valid),
    .mem_op_i       (mem_op),
    .mem_addr_i     (mem_addr),
    .mem_wdata_i    (mem_wdata),
    .flush_i        (flush),
    .mem_rdata_o    (mem_rdata),
    .mem_done_o     (mem_done),
    .stall_o        (stall),
    .adel_o         (adel),
    .ades_o         (ades),
    .badvaddr_o     (badvaddr),
    .data_req_o     (data_req),
    .data_wr_o      (data_wr),
    .data_size_o    (data_size),
    .data_addr_o    (data_addr),
    .data_wdata_o   (data_wdata),
    .data_wstrb_o   (data_wstrb),
    .data_addr_ok_i (addr_ok),
    .data_data_ok_i (data_ok),
    .data_rdata_i   (rdata_in),
    .bus_err_o      (bus_err)
  );
`else
  dsram_access_ctrl dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .mem_valid_i    (mem_valid),
    .mem_op_i       (mem_op),
    .mem_addr_i     (mem_addr),
    .mem_wdata_i    (mem_wdata),
    .flush_i        (flush),
    .mem_rdata_o    (mem_rdata),
    .mem_done_o     (mem_done),
    .stall_o        (stall),
    .adel_o         (adel),
    .ades_o         (ades),
    .badvaddr_o     (badvaddr),
    .data_req_o     (data_req),
    .data_wr_o      (data_wr),
    .data_size_o    (data_size),
    .data_addr_o    (data_addr),
    .data_wdata_o   (data_wdata),
    .data_wstrb_o   (data_wstrb),
    .data_addr_ok_i (addr_ok),
    .data_data_ok_i (data_ok),
    .data_rdata_i   (rdata_in)
  );
`endif

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Full transaction: accept, REQ with addr_ok, lat cycles to data_ok, DONE, back to IDLE.
  task automatic run_op(input string tag, input logic [7:0] op, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] rd, input logic [31:0] exp_rd,
                        input logic [3:0] exp_strb, input logic [31:0] exp_wd,
                        input logic [1:0] exp_size, input int lat, input bit is_load);
    mem_valid = 1'b1; mem_op = op; mem_addr = a; mem_wdata = wd;
    @(negedge clk);
    check({tag, ".accept_stall"}, 32'(stall), 32'd1);
    check({tag, ".no_addr_err"}, 32'({adel, ades}), 32'd0);
    next_cycle();
    addr_ok = 1'b1; data_ok = (lat == 0); rdata_in = rd;
    @(negedge clk);
    check({tag, ".req"}, 32'(data_req), 32'd1);
    check({tag, ".addr"}, data_addr, a);
    check({tag, ".strb"}, 32'(data_wstrb), 32'(exp_strb));
    check({tag, ".wdata"}, data_wdata, exp_wd);
    check({tag, ".size"}, 32'(data_size), 32'(exp_size));
    check({tag, ".wr"}, 32'(data_wr), 32'(!is_load));
    next_cycle();
    addr_ok = 1'b0;
    for (int i = 1; i <= lat; i++) begin
      data_ok = (i == lat);
      @(negedge clk);
      check({tag, ".wait_req"}, 32'(data_req), 32'd0);
      check({tag, ".wait_stall"}, 32'(stall), 32'd1);
      check({tag, ".wait_done"}, 32'(mem_done), 32'd0);
      next_cycle();
    end
    data_ok = 1'b0;
    @(negedge clk);
    check({tag, ".done"}, 32'(mem_done), 32'd1);
    check({tag, ".done_stall"}, 32'(stall), 32'd0);
    if (is_load) check({tag, ".rdata"}, mem_rdata, exp_rd);
    next_cycle();
    mem_valid = 1'b0;
    @(negedge clk);
    check({tag, ".done_pulse"}, 32'(mem_done), 32'd0);
    check({tag, ".idle_req"}, 32'(data_req), 32'd0);
    next_cycle();
  endtask

  // Op held in IDLE that must never reach the bus.
  task automatic reject_op(input string tag, input logic [7:0] op, input logic [31:0] a,
                           input bit exp_adel, input bit exp_ades);
    mem_valid = 1'b1; mem_op = op; mem_addr = a; mem_wdata = 32'h0BAD_0BAD;
    @(negedge clk);
    check({tag, ".adel"}, 32'(adel), 32'(exp_adel));
    check({tag, ".ades"}, 32'(ades), 32'(exp_ades));
    check({tag, ".badvaddr"}, badvaddr, a);
    check({tag, ".stall"}, 32'(stall), 32'd0);
    for (int i = 0; i < 2; i++) begin
      next_cycle();
      @(negedge clk);
      check({tag, ".no_req"}, 32'(data_req), 32'd0);
      check({tag, ".no_done"}, 32'(mem_done), 32'd0);
    end
    mem_valid = 1'b0;
    next_cycle();
  endtask

  initial begin
    rst = 1'b1; mem_valid = 1'b0; flush = 1'b0; addr_ok = 1'b0; data_ok = 1'b0;
    mem_op = '0; mem_addr = '0; mem_wdata = '0; rdata_in = '0;
    next_cycle();
    next_cycle();
    @(negedge clk);
    check("rst.req", 32'(data_req), 32'd0);
    check("rst.done", 32'(mem_done), 32'd0);
    check("rst.rdata", mem_rdata, 32'd0);
    check("rst.stall", 32'(stall), 32'd0);
    check("rst.strb", 32'(data_wstrb), 32'd0);
    rst = 1'b0;
    next_cycle();

    run_op("sw",  EXE_SW_OP,  32'h100, 32'hDEADBEEF, 32'h0,        32'h0,        4'hF, 32'hDEADBEEF, 2'd2, 0, 1'b0);
    run_op("lb",  EXE_LB_OP,  32'h103, 32'h0,        32'h80123456, 32'hFFFFFF80, 4'h0, 32'h0,        2'd0, 3, 1'b1);
    run_op("sh2", EXE_SH_OP,  32'h202, 32'h1234ABCD, 32'h0,        32'h0,        4'hC, 32'hABCD0000, 2'd1, 0, 1'b0);
    run_op("sh0", EXE_SH_OP,  32'h200, 32'hFFFF1234, 32'h0,        32'h0,        4'h3, 32'hFFFF1234, 2'd1, 1, 1'b0);
    run_op("sb",  EXE_SB_OP,  32'h101, 32'h0000005A, 32'h0,        32'h0,        4'h2, 32'h00005A00, 2'd0, 1, 1'b0);
    run_op("lbu", EXE_LBU_OP, 32'h102, 32'h0,        32'h12F45678, 32'h000000F4, 4'h0, 32'h0,        2'd0, 0, 1'b1);
    run_op("lh",  EXE_LH_OP,  32'h100, 32'h0,        32'h12348001, 32'hFFFF8001, 4'h0, 32'h0,        2'd1, 2, 1'b1);
    run_op("lhu", EXE_LHU_OP, 32'h102, 32'h0,        32'h87654321, 32'h00008765, 4'h0, 32'h0,        2'd1, 0, 1'b1);
    run_op("lw",  EXE_LW_OP,  32'h104, 32'h0,        32'hCAFEF00D, 32'hCAFEF00D, 4'h0, 32'h0,        2'd2, 1, 1'b1);

    reject_op("lh_mis",  EXE_LH_OP, 32'h101, 1'b1, 1'b0);
    reject_op("lw_mis",  EXE_LW_OP, 32'h102, 1'b1, 1'b0);
    reject_op("sw_mis",  EXE_SW_OP, 32'h101, 1'b0, 1'b1);
    reject_op("sh_mis",  EXE_SH_OP, 32'h203, 1'b0, 1'b1);
    reject_op("non_mem", 8'h00,     32'h101, 1'b0, 1'b0);

    // Flush while waiting for data: drain the response, no completion.
    mem_valid = 1'b1; mem_op = EXE_LW_OP; mem_addr = 32'h108;
    next_cycle();
    addr_ok = 1'b1;
    next_cycle();
    addr_ok = 1'b0; flush = 1'b1;
    @(negedge clk);
    check("flw.wait_stall", 32'(stall), 32'd1);
    next_cycle();
    flush = 1'b0;
    @(negedge clk);
    check("flw.drain_req", 32'(data_req), 32'd0);
    check("flw.drain_stall_valid", 32'(stall), 32'd1);
    next_cycle();
    mem_valid = 1'b0; data_ok = 1'b1; rdata_in = 32'h11111111;
    @(negedge clk);
    check("flw.drain_stall_idle", 32'(stall), 32'd0);
    check("flw.drain_done", 32'(mem_done), 32'd0);
    next_cycle();
    data_ok = 1'b0;
    @(negedge clk);
    check("flw.no_done", 32'(mem_done), 32'd0);
    check("flw.rdata_kept", mem_rdata, 32'hCAFEF00D);
    next_cycle();

    // Flush before addr_ok withdraws the request; a late data_ok is ignored.
    mem_valid = 1'b1; mem_op = EXE_LW_OP; mem_addr = 32'h10C;
    next_cycle();
    flush = 1'b1;
    @(negedge clk);
    check("flr.req", 32'(data_req), 32'd1);
    next_cycle();
    flush = 1'b0; mem_valid = 1'b0;
    @(negedge clk);
    check("flr.withdrawn", 32'(data_req), 32'd0);
    check("flr.stall", 32'(stall), 32'd0);
    data_ok = 1'b1;
    next_cycle();
    data_ok = 1'b0;
    @(negedge clk);
    check("flr.late_ok_done", 32'(mem_done), 32'd0);
    check("flr.late_ok_req", 32'(data_req), 32'd0);
    next_cycle();

    // Flush in the accept cycle blocks the op.
    mem_valid = 1'b1; mem_op = EXE_SW_OP; mem_addr = 32'h100; flush = 1'b1;
    @(negedge clk);
    check("fla.stall", 32'(stall), 32'd0);
    next_cycle();
    flush = 1'b0; mem_valid = 1'b0;
    @(negedge clk);
    check("fla.no_req", 32'(data_req), 32'd0);
    next_cycle();

    // Reset in the middle of a request.
    mem_valid = 1'b1; mem_op = EXE_SB_OP; mem_addr = 32'h100; mem_wdata = 32'h77;
    next_cycle();
    @(negedge clk);
    check("rstm.req", 32'(data_req), 32'd1);
    rst = 1'b1; mem_valid = 1'b0;
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    check("rstm.req_cleared", 32'(data_req), 32'd0);
    check("rstm.stall", 32'(stall), 32'd0);
    check("rstm.rdata", mem_rdata, 32'd0);
    next_cycle();

    run_op("sw_after", EXE_SW_OP, 32'h1F0, 32'h01020304, 32'h0, 32'h0, 4'hF, 32'h01020304, 2'd2, 0, 1'b0);

`ifdef DSRAM_TIMEOUT_EN
    // addr_ok never arrives: bus_err pulses 4 cycles after REQ.
    mem_valid = 1'b1; mem_op = EXE_LW_OP; mem_addr = 32'h110;
    next_cycle();
    mem_valid = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      check("to.bus_err_low", 32'(bus_err), 32'd0);
      check("to.req_held", 32'(data_req), 32'd1);
      next_cycle();
    end
    @(negedge clk);
    check("to.bus_err", 32'(bus_err), 32'd1);
    check("to.req_dropped", 32'(data_req), 32'd0);
    check("to.no_done", 32'(mem_done), 32'd0);
    check("to.stall", 32'(stall), 32'd0);
    next_cycle();
    @(negedge clk);
    check("to.bus_err_pulse", 32'(bus_err), 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish, checks=%0d", checks);
    $fatal(1);
  end

endmodule
